rr_bus_arbiter: RTL

- Round-robin arbiter that shares the single SoC bus between NMASTERS requesters: core iport, core dport and the UART bootloader.
- Sits between the masters and mux_switch. Registers the grant, forwards the winning master's request, and returns ready, error and read data to that master only.
- A per-transaction watchdog turns a hung slave access into a bus error, so a master never stalls forever.

---
 rtl/musb_bus_pkg.sv | 20 ++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/rr_bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/musb_bus_pkg.sv
// Shared musb SoC bus constants, arbiter state encoding and a constant-safe clog2.
package musb_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WR_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-and-find-first: returns the first set request at or after i_ptr, with wrap-around.
module rr_priority_pick
  import musb_bus_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_off;
  int             w_sum;

  // Doubling the request vector turns the wrap-around search into a plain shift.
  always_comb begin
    w_dbl   = {i_req, i_req};
    w_rot   = N'(w_dbl >> i_ptr);
    w_off   = 0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = i;
        o_found = 1'b1;
      end
    end
    w_sum = int'(i_ptr) + w_off;
    if (w_sum >= N) w_sum = w_sum - N;
    o_idx = IW'(w_sum);
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared musb bus with a per-access watchdog.
// Optional grant locking for bursts / atomic RMW is enabled with `define RR_ARB_LOCK_EN.
module rr_bus_arbiter
  import musb_bus_pkg::*;
#(
  parameter int NMASTERS       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W*NMASTERS-1:0]     master_address,
  input  logic [DATA_W*NMASTERS-1:0]     master_data_i,
  input  logic [WR_W*NMASTERS-1:0]       master_wr,
  input  logic [NMASTERS-1:0]            master_enable,
`ifdef RR_ARB_LOCK_EN
  input  logic [NMASTERS-1:0]            master_lock,
`endif
  output logic [DATA_W-1:0]              master_data_o,
  output logic [NMASTERS-1:0]            master_ready,
  output logic [NMASTERS-1:0]            master_error,
  input  logic [DATA_W-1:0]              slave_data_i,
  input  logic                           slave_ready,
  input  logic                           slave_error,
  output logic [ADDR_W-1:0]              slave_address,
  output logic [DATA_W-1:0]              slave_data_o,
  output logic [WR_W-1:0]                slave_wr,
  output logic                           slave_enable,
  output logic                           grant_valid,
  output logic [clog2(NMASTERS)-1:0]     grant_id
);

  localparam int GW = clog2(NMASTERS);
  localparam int CW = 16;

  arb_state_e    r_state;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] r_gid;
  logic          r_gvalid;
  logic [CW-1:0] r_cnt;

  logic [GW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic          w_en_g;
  logic [WR_W-1:0] w_wr_g;
  logic          w_busy;
  logic          w_err;
  logic          w_rdy;
  logic          w_to;
  logic          w_keep;
  logic          w_done;
  logic [GW-1:0] w_ptr_next;

  rr_priority_pick #(.N(NMASTERS), .IW(GW)) u_pick (
    .i_req   (master_enable),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_comb begin
    slave_address = '0;
    slave_data_o  = '0;
    w_wr_g        = '0;
    w_en_g        = 1'b0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (r_gid == GW'(k)) begin
        slave_address = master_address[ADDR_W*k +: ADDR_W];
        slave_data_o  = master_data_i[DATA_W*k +: DATA_W];
        w_wr_g        = master_wr[WR_W*k +: WR_W];
        w_en_g        = master_enable[k];
      end
    end
  end

  // Completion precedence: error, then ready, then watchdog. Reset masks all pulses.
  assign w_busy = (r_state == BUSY) && !rst && w_en_g;
  assign w_err  = w_busy && slave_error;
  assign w_rdy  = w_busy && !slave_error && slave_ready;
  assign w_to   = w_busy && !slave_error && !slave_ready && (r_cnt == CW'(TIMEOUT_CYCLES));

`ifdef RR_ARB_LOCK_EN
  assign w_keep = w_rdy && master_lock[r_gid];
`else
  assign w_keep = 1'b0;
`endif

  assign w_done     = w_err || w_to || (w_rdy && !w_keep);
  assign w_ptr_next = (r_gid == GW'(NMASTERS - 1)) ? '0 : r_gid + GW'(1);

  assign slave_enable  = w_busy && !w_to;
  assign slave_wr      = w_busy ? w_wr_g : '0;
  assign master_data_o = (|master_ready) ? slave_data_i : '0;
  assign grant_valid   = r_gvalid;
  assign grant_id      = r_gid;

  always_comb begin
    master_ready = '0;
    master_error = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      master_ready[k] = w_rdy && (r_gid == GW'(k));
      master_error[k] = (w_err || w_to) && (r_gid == GW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_gvalid <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_gid    <= w_pick_idx;
            r_gvalid <= 1'b1;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          // A dropped request is an abort: no pulse and the pointer stays put.
          if (!w_en_g) begin
            r_state  <= IDLE;
            r_gvalid <= 1'b0;
          end else if (w_done) begin
            r_state  <= IDLE;
            r_gvalid <= 1'b0;
            r_ptr    <= w_ptr_next;
          end else if (w_keep) begin
            r_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
